// File: rtl/vector_mem_unit_if.sv
// Halfword memory port of the vector load/store sequencer.
// master = sequencer side, slave = data memory side.
interface vector_mem_unit_if #(
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [ELEM_W-1:0] mem_wdata;
  logic [ELEM_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_re,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vector_mem_unit.sv
// Multi-cycle VLD/VST sequencer: one vector <-> 16 halfword accesses.
// Optional VMU_WRAP_ERR_EN rejects requests whose span wraps the address space.
module vector_mem_unit #(
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       is_store,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ELEM_W*NUM_ELEM-1:0] st_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ELEM_W*NUM_ELEM-1:0] ld_data,
  vector_mem_unit_if.master          mem
);

  localparam int IW = $clog2(NUM_ELEM);
  localparam logic [IW-1:0] LAST = IW'(NUM_ELEM - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STORE  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_LDRAIN = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_d;
  logic [IW-1:0]     idx;
  logic [ADDR_W-1:0] base_q;
  logic              err_q;
  logic              accept;
  logic              wrap;
  logic              do_st;
  logic              do_ld;

  logic [NUM_ELEM-1:0][ELEM_W-1:0] data_q;
  logic [NUM_ELEM-1:0][ELEM_W-1:0] shadow;

`ifdef VMU_WRAP_ERR_EN
  logic [ADDR_W:0] end_sum;
  assign end_sum = {1'b0, base_addr} + (ADDR_W+1)'(NUM_ELEM - 1);
  assign wrap    = end_sum[ADDR_W];
`else
  assign wrap    = 1'b0;
`endif

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign do_st  = (state == S_STORE);
  assign do_ld  = (state == S_LOAD);
  assign err    = err_q;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept && !wrap)
          state_d = is_store ? S_STORE : S_LOAD;
      end
      S_STORE:  if (idx == LAST) state_d = S_DONE;
      S_LOAD:   if (idx == LAST) state_d = S_LDRAIN;
      S_LDRAIN: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_q   <= 1'b0;
      idx     <= '0;
      base_q  <= '0;
      data_q  <= '0;
      shadow  <= '0;
      ld_data <= '0;
    end else begin
      state <= state_d;
      busy  <= (state_d == S_STORE) || (state_d == S_LOAD)
            || (state_d == S_LDRAIN);
      done  <= (state_d == S_DONE);
      err_q <= accept && wrap;
      if (accept) begin
        idx    <= '0;
        base_q <= base_addr;
        if (is_store) data_q <= st_data;
      end else if (do_st || do_ld) begin
        idx <= idx + 1'b1;
      end
      // read data lags its strobe by one cycle, so it lands in idx-1
      if (do_ld && idx != '0)
        shadow[idx - 1'b1] <= mem.mem_rdata;
      if (state == S_LDRAIN) begin
        shadow[LAST] <= mem.mem_rdata;
        ld_data <= {mem.mem_rdata, shadow[NUM_ELEM-2:0]};
      end
    end
  end

  assign mem.mem_we    = do_st;
  assign mem.mem_re    = do_ld;
  assign mem.mem_addr  = (do_st || do_ld) ? base_q + ADDR_W'(idx) : '0;
  assign mem.mem_wdata = do_st ? data_q[idx] : '0;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit: strobe scoreboard plus
// table-driven transfers and hand-written reset/wrap sequences.
module tb_vector_mem_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         is_store = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [255:0] st_data = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [255:0] ld_data;

  vector_mem_unit_if #(.ELEM_W(16), .ADDR_W(16)) mif();

  vector_mem_unit #(.ELEM_W(16), .NUM_ELEM(16), .ADDR_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .is_store(is_store),
    .base_addr(base_addr),
    .st_data(st_data),
    .busy(busy),
    .done(done),
    .err(err),
    .ld_data(ld_data),
    .mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } strb_t;

  typedef struct {
    bit          st;
    logic [15:0] base;
    logic [15:0] seed;
    int          lat;
    bit          spam;
    bit          chain;
  } vec_t;

  strb_t        sq[$];
  strb_t        e;
  vec_t         vt[$];
  int           total = 0;
  int           bad = 0;
  bit           mon_on = 1'b0;
  logic [255:0] exp_ld = '0;

  // 1-cycle latency memory; junk when not reading
  always @(posedge clk)
    mif.mem_rdata <= mif.mem_re ? (16'h4000 | {12'h0, mif.mem_addr[3:0]})
                                : 16'hDEAD;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (mif.mem_re || mif.mem_we) begin
        chk("re_we_excl", 256'(mif.mem_re & mif.mem_we), 256'(0));
        if (sq.size() == 0) begin
          chk("unexpected_strobe",
              256'({mif.mem_re, mif.mem_we, mif.mem_addr}), 256'(0));
        end else begin
          e = sq.pop_front();
          chk("strobe_we", 256'(mif.mem_we), 256'(e.we));
          chk("strobe_re", 256'(mif.mem_re), 256'(!e.we));
          chk("strobe_addr", 256'(mif.mem_addr), 256'(e.addr));
          if (e.we)
            chk("strobe_wdata", 256'(mif.mem_wdata), 256'(e.wdata));
        end
      end else begin
        chk("idle_bus", 256'({mif.mem_addr, mif.mem_wdata}), 256'(0));
      end
    end
  end

  task automatic push_exp(input bit st, input logic [15:0] base,
                          input logic [15:0] seed,
                          output logic [255:0] sd,
                          output logic [255:0] nl);
    logic [15:0] a;
    sd = '0;
    nl = '0;
    for (int i = 0; i < 16; i++) begin
      a = base + 16'(i);
      sd[16*i +: 16] = seed + 16'(i);
      nl[16*i +: 16] = 16'h4000 | {12'h0, a[3:0]};
      sq.push_back('{we: st, addr: a, wdata: st ? seed + 16'(i) : 16'h0});
    end
  endtask

  task automatic xfer(input vec_t v);
    logic [255:0] sd;
    logic [255:0] nl;
    push_exp(v.st, v.base, v.seed, sd, nl);
    start     = 1'b1;
    is_store  = v.st;
    base_addr = v.base;
    st_data   = sd;
    @(posedge clk);
    #1;
    start   = 1'b0;
    st_data = {8{$urandom}};
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      chk("err_low", 256'(err), 256'(0));
      if (c < v.lat) begin
        chk("busy_hi", 256'(busy), 256'(1));
        chk("done_lo", 256'(done), 256'(0));
        chk("ld_hold", ld_data, exp_ld);
      end else begin
        chk("done_hi", 256'(done), 256'(1));
        chk("busy_lo_done", 256'(busy), 256'(0));
        if (!v.st) exp_ld = nl;
        chk("ld_data", ld_data, exp_ld);
      end
      if (v.spam) begin
        start     = (c < v.lat - 1);
        is_store  = 1'($urandom);
        base_addr = 16'($urandom);
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_ld", ld_data, 256'(0));
    chk("rst_bus", 256'({mif.mem_re, mif.mem_we, mif.mem_addr,
                         mif.mem_wdata}), 256'(0));
    #9 rst = 1'b0;
    mon_on = 1'b1;

    vt.push_back('{1'b1, 16'h0100, 16'h3C00, 17, 1'b0, 1'b0});
    vt.push_back('{1'b0, 16'h0200, 16'h0000, 18, 1'b0, 1'b0});
    vt.push_back('{1'b0, 16'h0208, 16'h0000, 18, 1'b1, 1'b0});
    vt.push_back('{1'b1, 16'h1234, 16'h1111, 17, 1'b0, 1'b1});
    vt.push_back('{1'b0, 16'h0A07, 16'h0000, 18, 1'b0, 1'b1});
    vt.push_back('{1'b1, 16'h0300, 16'hA5A0, 17, 1'b1, 1'b0});
`ifndef VMU_WRAP_ERR_EN
    vt.push_back('{1'b1, 16'hFFF8, 16'h7700, 17, 1'b0, 1'b0});
    vt.push_back('{1'b0, 16'hFFF8, 16'h0000, 18, 1'b0, 1'b1});
`endif
    vt.push_back('{1'b0, 16'h0A07, 16'h0000, 18, 1'b0, 1'b0});

    foreach (vt[k]) begin
      if (!vt[k].chain) begin
        @(posedge clk);
        #1;
      end
      xfer(vt[k]);
    end

    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 256'(busy), 256'(0));
      chk("idle_done", 256'(done), 256'(0));
    end

    begin : mid_reset
      logic [255:0] sd;
      logic [255:0] nl;
      @(posedge clk);
      #1;
      push_exp(1'b0, 16'h0400, 16'h0, sd, nl);
      start     = 1'b1;
      is_store  = 1'b0;
      base_addr = 16'h0400;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_re", 256'(mif.mem_re), 256'(0));
      chk("mid_rst_busy", 256'(busy), 256'(0));
      chk("mid_rst_done", 256'(done), 256'(0));
      chk("mid_rst_ld", ld_data, 256'(0));
      chk("mid_rst_drained", 256'(sq.size()), 256'(8));
      sq.delete();
      exp_ld = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (20) begin
        @(negedge clk);
        chk("post_rst_done", 256'(done), 256'(0));
        chk("post_rst_ld", ld_data, 256'(0));
      end
      @(posedge clk);
      #1;
      xfer('{1'b0, 16'h0200, 16'h0, 18, 1'b0, 1'b0});
    end

`ifdef VMU_WRAP_ERR_EN
    @(posedge clk);
    #1;
    start     = 1'b1;
    is_store  = 1'b0;
    base_addr = 16'hFFF8;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("wrap_err", 256'(err), 256'(1));
    chk("wrap_busy", 256'(busy), 256'(0));
    repeat (18) begin
      @(negedge clk);
      chk("wrap_err_pulse", 256'(err), 256'(0));
      chk("wrap_no_done", 256'(done), 256'(0));
      chk("wrap_ld_hold", ld_data, exp_ld);
    end
`endif

    @(negedge clk);
    chk("queue_empty", 256'(sq.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_mem_unit.md
# vector_mem_unit

Multi-cycle vector load/store sequencer on the far side of the ALU's VLD/VST address path. The ALU produces the effective address (base + offset); this block consumes it and moves one 256-bit vector (16 half-precision elements) between the vector register file and a 16-bit-wide halfword-addressed data memory. It sits between execute and writeback and stalls the pipeline through `busy` while a transfer is in flight.

## Interface
- `ELEM_W`, 16, element width in bits (half-precision float).
- `NUM_ELEM`, 16, elements per vector; `ELEM_W*NUM_ELEM` = 256.
- `ADDR_W`, 16, memory address width (halfword addressed).

- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request strobe; sampled only when `busy`=0.
- `is_store`  input  1  1 = VST, 0 = VLD; sampled with `start`.
- `base_addr`  input  ADDR_W  effective address from ALU `result[15:0]`.
- `st_data`  input  256  store vector; element i = bits [16i+15:16i].
- `busy`  output  1  transfer in progress.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  one-cycle address-wrap error pulse (see Configuration).
- `ld_data`  output  256  completed load vector; element i = bits [16i+15:16i].
- `mem_addr`  output  ADDR_W  memory address.
- `mem_re`  output  1  memory read strobe.
- `mem_we`  output  1  memory write strobe.
- `mem_wdata`  output  ELEM_W  write data.
- `mem_rdata`  input  ELEM_W  read data, valid the cycle after `mem_re`.

## Operation
- States: IDLE, STORE, LOAD, LDRAIN, DONE.
- IDLE: `start`=1 at an edge latches `is_store`, `base_addr`, `st_data` (store only), clears the element counter `idx`, and enters STORE or LOAD. `start` while `busy`=1 is ignored, not queued.
- STORE: each cycle drive `mem_we`=1, `mem_addr`=base+idx, `mem_wdata`=latched element idx; idx increments. After idx=15 go to DONE.
- LOAD: each cycle drive `mem_re`=1, `mem_addr`=base+idx; idx increments. `mem_rdata` captured at the next edge into shadow element idx-1. After issuing idx=15 go to LDRAIN. LDRAIN captures element 15, copies the full shadow to `ld_data`, and goes to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE. `start` in DONE is accepted exactly as in IDLE.
- `ld_data` changes only at the edge entering DONE after a load. It holds through stores and idle time.
- Addresses: base+idx computed modulo 2^ADDR_W. Element 0 is at the lowest address.
- `mem_re` and `mem_we` are never both 1. Both are 0 outside STORE/LOAD.
- `mem_addr` and `mem_wdata` are 0 when no strobe is active.

## Timing
- Reset: state IDLE. `busy`, `done`, `err`, `mem_re`, `mem_we` = 0. `mem_addr`, `mem_wdata`, `ld_data`, idx, shadow = 0.
- Reset mid-transfer aborts immediately. No further strobes are issued, no `done` pulse occurs, and `ld_data` is cleared.
- `busy` is registered. It rises the cycle after the accepting edge and stays high through the last strobe/drain cycle.
- Store, with accepting edge E0: `mem_we` high cycles 1–16; `done` in cycle 17. Back-to-back issue is possible, so the next start can be accepted at the edge ending cycle 17.
- Load, with accepting edge E0: `mem_re` high cycles 1–16; LDRAIN cycle 17; `done` and new `ld_data` in cycle 18.

## Configuration
- `VMU_WRAP_ERR_EN` defined:
  - A request whose base+15 exceeds 2^ADDR_W−1 is rejected.
  - `err` pulses one cycle after the accepting edge.
  - No strobes, no `done`, `ld_data` unchanged; state returns to IDLE.
- `VMU_WRAP_ERR_EN` undefined:
  - Addresses wrap modulo 2^ADDR_W.
  - `err` is tied 0.

## Test plan
- Reset values: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately, state IDLE.
- Store: start, is_store=1, base=0x0100, st_data element i = 0x3C00+i -> 16 writes to 0x0100..0x010F with 0x3C00..0x3C0F in cycles 1–16, `done` in cycle 17, `mem_re` never 1.
- Load: memory model with 1-cycle latency returning 0x4000+addr[3:0], base=0x0200 -> reads 0x0200..0x020F, `ld_data` element i = 0x4000+i in cycle 18 with `done`, `ld_data` stable before that.
- Ignored start / back-to-back: pulse start every cycle during a load -> only one transfer. Start in the DONE cycle -> next transfer begins with no idle gap.
- Reset mid-load after 8 reads -> no further `mem_re`, no `done`, `ld_data`=0, a fresh load then completes normally.
- Wrap, base=0xFFF8:
  - with `VMU_WRAP_ERR_EN` -> `err` pulse, zero strobes.
  - without it -> addresses 0xFFF8..0xFFFF, 0x0000..0x0007.
